// File: rtl/karatsuba_pkg.sv
// Shared definitions for the sequential Karatsuba carry-less multiplier:
// FSM state encoding, product-width helper and the default field polynomial.
package karatsuba_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUL_H   = 3'd1,
    ST_MUL_L   = 3'd2,
    ST_MUL_M   = 3'd3,
    ST_COMBINE = 3'd4,
    ST_REDUCE  = 3'd5,
    ST_DONE    = 3'd6
  } state_t;

  // x^8 + x^4 + x^3 + x + 1 with the x^8 term implicit
  localparam logic [7:0] DEFAULT_POLY = 8'h1B;

  function automatic int clmul_width(input int n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/karatsuba_clmul_seq_clmul_comb.sv
// Purely combinational N x N carry-less (GF(2)) multiplier, 2N-1 bit product.
module clmul_comb
  import karatsuba_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]                a_i,
  input  logic [N-1:0]                b_i,
  output logic [clmul_width(N)-1:0]   p_o
);

  always_comb begin
    p_o = '0;
    for (int i = 0; i < N; i++) begin
      if (b_i[i]) begin
        p_o = p_o ^ ({{(N-1){1'b0}}, a_i} << i);
      end
    end
  end

endmodule

// File: rtl/karatsuba_clmul_seq.sv
// Sequential Karatsuba carry-less multiplier: one shared half-width multiplier
// produces C1/C4/C5 over three cycles, then optional bit-serial field reduction.
module karatsuba_clmul_seq
  import karatsuba_pkg::*;
#(
  parameter int           W    = 8,
  parameter logic [W-1:0] POLY = W'(DEFAULT_POLY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-2:0]   out_data,
  output logic             busy
);

  localparam int H  = W / 2;
  localparam int CW = clmul_width(H);
  localparam int PW = 2 * W - 1;
  localparam int KW = $clog2(W);

  state_t          state_q;
  logic [W-1:0]    a_q, b_q;
  logic            mode_q;
  logic [CW-1:0]   c1_q, c4_q, c5_q;
  logic [PW-1:0]   p_q;
  logic [KW-1:0]   k_q;
  logic            busy_q, out_valid_q;

  logic [H-1:0]    mul_a, mul_b;
  logic [CW-1:0]   mul_p;
  logic [CW-1:0]   c6;
  logic [PW-1:0]   p_d;
  logic [PW-1:0]   top_mask, red_base, p_red_d;
  logic [KW-1:0]   shamt;

  // One multiplier, operands steered by which sub-product is being formed
  always_comb begin
    mul_a = a_q[W-1:H];
    mul_b = b_q[W-1:H];
    case (state_q)
      ST_MUL_L: begin
        mul_a = a_q[H-1:0];
        mul_b = b_q[H-1:0];
      end
      ST_MUL_M: begin
        mul_a = a_q[W-1:H] ^ a_q[H-1:0];
        mul_b = b_q[W-1:H] ^ b_q[H-1:0];
      end
      default: ;
    endcase
  end

  clmul_comb #(.N(H)) u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  always_comb begin
    c6  = c5_q ^ c1_q ^ c4_q;
    p_d = {c1_q, {W{1'b0}}}
        ^ {{H{1'b0}}, c6, {H{1'b0}}}
        ^ {{W{1'b0}}, c4_q};
  end

  // Step k clears bit 2W-2-k by folding {1,POLY} aligned under it
  always_comb begin
    top_mask = {1'b1, {(PW-1){1'b0}}} >> k_q;
    red_base = {{(W-2){1'b0}}, 1'b1, POLY};
    shamt    = KW'(W - 2) - k_q;
    p_red_d  = p_q;
    if (|(p_q & top_mask)) begin
      p_red_d = p_q ^ (red_base << shamt);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      mode_q      <= 1'b0;
      c1_q        <= '0;
      c4_q        <= '0;
      c5_q        <= '0;
      p_q         <= '0;
      k_q         <= '0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            mode_q  <= in_mode;
            busy_q  <= 1'b1;
            state_q <= ST_MUL_H;
          end
        end
        ST_MUL_H: begin
          c1_q    <= mul_p;
          state_q <= ST_MUL_L;
        end
        ST_MUL_L: begin
          c4_q    <= mul_p;
          state_q <= ST_MUL_M;
        end
        ST_MUL_M: begin
          c5_q    <= mul_p;
          state_q <= ST_COMBINE;
        end
        ST_COMBINE: begin
          p_q <= p_d;
          k_q <= '0;
          if (mode_q) begin
            state_q <= ST_REDUCE;
          end else begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_REDUCE: begin
          p_q <= p_red_d;
          k_q <= k_q + KW'(1);
          if (k_q == KW'(W - 2)) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE) && rst_n;
  assign out_valid = out_valid_q;
  assign out_data  = p_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_karatsuba_clmul_seq.sv
// Directed and randomised bench for karatsuba_clmul_seq (W=8 default and W=16).
module tb_karatsuba_clmul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  int          nvec = 0;
  int          nerr = 0;
  int          cyc  = 0;

  logic        in_valid, in_ready, in_mode, out_valid, out_ready, busy;
  logic [7:0]  in_a, in_b;
  logic [14:0] out_data;

  logic        v16, irdy16, m16, ovld16, ordy16, busy16;
  logic [15:0] a16, b16;
  logic [30:0] od16;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  karatsuba_clmul_seq u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  karatsuba_clmul_seq #(.W(16), .POLY(16'h002B)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v16), .in_ready(irdy16),
    .in_a(a16), .in_b(b16), .in_mode(m16),
    .out_valid(ovld16), .out_ready(ordy16),
    .out_data(od16), .busy(busy16)
  );

  // Bit-serial reference: schoolbook product, then reduce from the top bit down
  function automatic logic [30:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                        input logic m);
    logic [30:0] p;
    logic [30:0] poly;
    p = '0;
    for (int i = 0; i < 16; i++)
      if (b[i]) p = p ^ ({15'd0, a} << i);
    if (m) begin
      poly = {14'd0, 1'b1, 16'h002B};
      for (int i = 30; i >= 16; i--)
        if (p[i]) p = p ^ (poly << (i - 16));
    end
    return p;
  endfunction

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic m,
                      output logic [14:0] data, output int lat);
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_mode = m;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    data = out_data;
  endtask

  task automatic handoff8();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nvec++;
    if (out_valid !== 1'b0 || out_data !== 15'h0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL reset_state: ov=%b od=%h busy=%b ir=%b, want 0 0 0 0",
               out_valid, out_data, busy, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 1'b1) begin
      nerr++;
      $display("FAIL ready_after_reset: got %b want 1", in_ready);
    end
  endtask

  task automatic test_full_product();
    logic [14:0] d;
    int lat;
    run8(8'h57, 8'h83, 1'b0, d, lat);
    nvec++;
    if (d !== 15'h2B79) begin nerr++; $display("FAIL full_57x83: got %h want 2b79", d); end
    nvec++;
    if (lat !== 4) begin nerr++; $display("FAIL lat_mode0: got %0d want 4", lat); end
    nvec++;
    if (busy !== 1'b1) begin nerr++; $display("FAIL busy_in_done: got %b want 1", busy); end
    handoff8();
    run8(8'hFF, 8'hFF, 1'b0, d, lat);
    nvec++;
    if (d !== 15'h5555) begin nerr++; $display("FAIL full_FFxFF: got %h want 5555", d); end
    handoff8();
    run8(8'h00, 8'hFF, 1'b0, d, lat);
    nvec++;
    if (d !== 15'h0000) begin nerr++; $display("FAIL full_00xFF: got %h want 0000", d); end
    handoff8();
    run8(8'h02, 8'h80, 1'b0, d, lat);
    nvec++;
    if (d !== 15'h0100) begin nerr++; $display("FAIL full_02x80: got %h want 0100", d); end
    handoff8();
  endtask

  task automatic test_reduced();
    logic [14:0] d;
    int lat;
    run8(8'h57, 8'h83, 1'b1, d, lat);
    nvec++;
    if (d !== 15'h00C1) begin nerr++; $display("FAIL red_57x83: got %h want 00c1", d); end
    nvec++;
    if (lat !== 11) begin nerr++; $display("FAIL lat_mode1: got %0d want 11", lat); end
    handoff8();
    run8(8'h01, 8'hA7, 1'b1, d, lat);
    nvec++;
    if (d !== 15'h00A7) begin nerr++; $display("FAIL red_01xA7: got %h want 00a7", d); end
    handoff8();
    run8(8'hFF, 8'hFF, 1'b1, d, lat);
    nvec++;
    if (d !== 15'h0013) begin nerr++; $display("FAIL red_FFxFF: got %h want 0013", d); end
    handoff8();
    run8(8'h02, 8'h80, 1'b1, d, lat);
    nvec++;
    if (d !== 15'h001B) begin nerr++; $display("FAIL red_02x80: got %h want 001b", d); end
    handoff8();
  endtask

  task automatic test_backpressure();
    logic [14:0] d;
    int lat;
    int bad;
    run8(8'h57, 8'h83, 1'b0, d, lat);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0]; in_a = 8'hC3 + 8'(i); in_b = 8'h5A; in_mode = ~i[1];
      @(posedge clk); #1;
      nvec++;
      if (out_valid !== 1'b1 || out_data !== 15'h2B79 || in_ready !== 1'b0) begin
        nerr++; bad++;
        $display("FAIL backpressure_%0d: ov=%b od=%h ir=%b want 1 2b79 0",
                 i, out_valid, out_data, in_ready);
      end
    end
    @(negedge clk); in_valid = 1'b0;
    handoff8();
    nvec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL after_handoff: ir=%b ov=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
    end
    repeat (6) @(posedge clk);
    #1;
    nvec++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL no_ghost_op: ov=%b busy=%b want 0 0", out_valid, busy);
    end
    run8(8'h03, 8'h03, 1'b0, d, lat);
    nvec++;
    if (d !== 15'h0005) begin nerr++; $display("FAIL post_bp_03x03: got %h want 0005", d); end
    handoff8();
  endtask

  task automatic test_reset_mid_reduce();
    logic [14:0] d;
    int lat;
    int seen;
    @(negedge clk);
    in_valid = 1'b1; in_a = 8'h57; in_b = 8'h83; in_mode = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    nvec++;
    if (out_valid !== 1'b0 || out_data !== 15'h0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      nerr++;
      $display("FAIL mid_reset: ov=%b od=%h busy=%b ir=%b want 0 0 0 0",
               out_valid, out_data, busy, in_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    nvec++;
    if (in_ready !== 1'b1) begin nerr++; $display("FAIL idle_after_mid_reset: ir=%b want 1", in_ready); end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    nvec++;
    if (seen !== 0) begin nerr++; $display("FAIL spurious_result: got %0d cycles want 0", seen); end
    run8(8'h57, 8'h83, 1'b1, d, lat);
    nvec++;
    if (d !== 15'h00C1) begin nerr++; $display("FAIL post_reset_op: got %h want 00c1", d); end
    handoff8();
  endtask

  task automatic test_back_to_back();
    logic [14:0] d1, d2;
    int lat;
    int c1, c2;
    run8(8'h0F, 8'h0F, 1'b0, d1, lat);
    c1 = cyc - lat;
    handoff8();
    run8(8'hF0, 8'h01, 1'b0, d2, lat);
    c2 = cyc - lat;
    nvec++;
    if (d1 !== 15'h0055 || d2 !== 15'h00F0) begin
      nerr++;
      $display("FAIL b2b_results: got %h %h want 0055 00f0", d1, d2);
    end
    nvec++;
    if (c2 - c1 < 5) begin nerr++; $display("FAIL b2b_spacing: got %0d want >=5", c2 - c1); end
    handoff8();
  endtask

  task automatic test_random16();
    logic [31:0] r;
    logic [30:0] exp;
    int lat;
    int acc, prev_acc;
    prev_acc = -100;
    for (int n = 0; n < 1000; n++) begin
      r = $urandom;
      @(negedge clk);
      v16 = 1'b1; a16 = r[15:0]; b16 = r[31:16]; m16 = n[0] ^ r[3];
      exp = ref16(a16, b16, m16);
      @(posedge clk); #1;
      v16 = 1'b0;
      acc = cyc;
      lat = 0;
      while (!ovld16 && lat < 60) begin
        @(posedge clk); #1;
        lat++;
      end
      nvec++;
      if (od16 !== exp || lat !== (m16 ? 19 : 4)) begin
        nerr++;
        $display("FAIL rand16_%0d: a=%h b=%h m=%b got %h lat %0d want %h lat %0d",
                 n, a16, b16, m16, od16, lat, exp, m16 ? 19 : 4);
      end
      nvec++;
      if (acc - prev_acc < 5) begin
        nerr++;
        $display("FAIL rand16_spacing_%0d: got %0d want >=5", n, acc - prev_acc);
      end
      prev_acc = acc;
      @(negedge clk); ordy16 = 1'b1;
      @(posedge clk); #1; ordy16 = 1'b0;
    end
  endtask

  initial begin
    in_valid = 1'b0; in_a = '0; in_b = '0; in_mode = 1'b0; out_ready = 1'b0;
    v16 = 1'b0; a16 = '0; b16 = '0; m16 = 1'b0; ordy16 = 1'b0;
    test_reset();
    test_full_product();
    test_reduced();
    test_backpressure();
    test_reset_mid_reduce();
    test_back_to_back();
    test_random16();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/karatsuba_clmul_seq.md
# karatsuba_clmul_seq

Parametrised, sequential carry-less (GF(2)) Karatsuba multiplier with valid/ready handshakes. It computes the full 2W-1 bit polynomial product, or the product reduced modulo a fixed field polynomial (GF(2^W) mode). One shared half-width carry-less multiplier is time-multiplexed across the three Karatsuba sub-products. It is the area-reduced, multi-cycle successor to the fixed-width combinational Karatsuba multipliers, intended for GF/GCM-style datapaths.

## Interface
Parameters:
- W, 8, operand width; must be even and >= 4; H = W/2
- POLY, 8'h1B, low W bits of the reduction polynomial; the x^W term is implicit (default is x^8+x^4+x^3+x+1)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operand request
- in_ready  out  1  high only in IDLE with rst_n high
- in_a  in  W  operand A
- in_b  in  W  operand B
- in_mode  in  1  0 = full product, 1 = reduced mod {1,POLY}
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- out_data  out  2W-1  result; in mode 1, bits [2W-2:W] are zero
- busy  out  1  high in every state except IDLE

## Operation
- All arithmetic is over GF(2): addition is XOR, no carries.
- Split: Ah=A[W-1:H], Al=A[H-1:0], and likewise for B. Sum operands: Am=Ah^Al, Bm=Bh^Bl.
- Products: C1=Ah·Bh, C4=Al·Bl, C5=Am·Bm. Each is 2H-1 bits.
- Middle term: C6=C5^C1^C4.
- Full product: P=(C1<<W)^(C6<<H)^C4, 2W-1 bits.
- FSM states: IDLE, MUL_H, MUL_L, MUL_M, COMBINE, REDUCE, DONE.
  - IDLE: on in_valid&&in_ready, register A, B and mode, then go to MUL_H.
  - MUL_H: register C1, then go to MUL_L.
  - MUL_L: register C4, then go to MUL_M.
  - MUL_M: register C5, then go to COMBINE.
  - COMBINE: register P. Go to DONE if mode=0, else go to REDUCE with counter k=0.
  - REDUCE: one step per cycle for bit i=2W-2-k, k=0..W-2. If P[i]=1, then P ^= {1,POLY}<<(i-W). After the k=W-2 step, go to DONE.
  - DONE: out_valid=1 and out_data=P. On out_ready, go to IDLE.
- A new operand is never accepted in the same cycle as the DONE handoff, so throughput is at most one operation per 5 cycles.
- in_valid is ignored while busy. Operands are captured only at the accept edge, so changes to in_a/in_b/in_mode afterwards have no effect.
- out_data and out_valid stay stable in DONE for any length of out_ready-low backpressure.
- Reset: with rst_n low at an edge, the block enters IDLE and clears out_valid, out_data, busy and all internal registers. in_ready is 0 while rst_n is low. Reset mid-operation discards the operation and produces no output.

## Timing
- Latency is counted from the accept edge (edge 0) to the edge that raises out_valid.
  - mode 0: 4 edges
  - mode 1: W+3 edges (11 for W=8)
- in_ready rises combinationally in the cycle after the DONE&&out_ready edge. The earliest next accept is that edge + 1.
- busy is registered and is high from edge 0 until the DONE handoff edge.
- out_valid is registered and never asserts combinationally from inputs.

## Structure
- Shared package karatsuba_pkg holds:
  - the state encoding constants
  - a function clmul_width(n) returning 2n-1
  - the default POLY constant
- Sub-module clmul_comb #(N=H): purely combinational N×N carry-less multiplier with output width 2N-1. It is instantiated exactly once and its operands are muxed by state.
- The reduction step is inline, shift-and-XOR on the P register.

## Test plan
- W=8, mode 0, A=8'h57, B=8'h83 -> out_data=15'h2B79 exactly 4 edges after accept.
- W=8, mode 1, A=8'h57, B=8'h83 -> out_data=15'h00C1 exactly 11 edges after accept.
- W=8, mode 0, A=B=8'hFF -> 15'h5555. Also A=8'h00, B=8'hFF -> 0, and mode 1 A=8'h01, B=8'hXY -> 8'hXY.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data are stable and in_ready=0. Toggling in_valid with new operands meanwhile has no effect.
- Reset mid-REDUCE (rst_n=0 for 1 edge) -> IDLE next cycle, out_valid=0, out_data=0, no spurious result. The next operation is correct.
- W=16, POLY=16'h002B: 1000 random operands in both modes against a bit-serial reference model -> all match. Back-to-back accepts are spaced at least 5 cycles.
